// File: rtl/fp_normalizer.sv
// fp_normalizer
//   Normalizes the raw mantissa sum of a floating-point adder into an
//   IEEE-754 single-precision word. A carry-out is folded back with one right
//   shift during capture. A leading-zero mantissa is shifted left one bit per
//   cycle in SHIFT until the hidden bit is set.
//
//   Ports
//     clk, rst              rising-edge clock, asynchronous active-high reset
//     in_valid / in_ready   operand handshake (ready only while IDLE)
//     in_sign, in_exp       sign and biased exponent of the raw sum
//     in_mant[24:0]         raw mantissa: bit24 carry-out, bit23 hidden bit
//     out_valid / out_ready result handshake (valid only while DONE)
//     out_result[31:0]      {sign, exp, frac}
//     out_zero/ovf/unf      exact zero / overflow to inf / underflow flush
//
//   Build option
//     FP_NORMALIZER_ROUND_EN  round-to-nearest-even on the bit dropped by the
//                             carry-out right shift (default: truncate)
//
//   state | meaning
//   IDLE  | waiting for an operand; in_ready = 1
//   SHIFT | left-normalizing one bit per cycle
//   DONE  | result held on the outputs until out_ready
module fp_normalizer #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [FRAC_W+1:0]       in_mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_result,
  output logic                    out_zero,
  output logic                    out_ovf,
  output logic                    out_unf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [7:0]  exp_q, exp_d;
  // Only the stored fraction is kept; in SHIFT the hidden bit is known to be 0.
  logic [22:0] frac_q, frac_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  // Carry-out path: fraction and exponent after the right shift (and rounding).
  logic [22:0] rs_frac;
  logic [8:0]  rs_exp;
`ifdef FP_NORMALIZER_ROUND_EN
  logic [24:0] rnd_sum;
`endif

  always_comb begin
    rs_frac = in_mant[23:1];
    rs_exp  = {1'b0, in_exp} + 9'd1;
`ifdef FP_NORMALIZER_ROUND_EN
    // Guard bit is in_mant[0], LSB after the shift is in_mant[1]; a tie only
    // rounds up toward an even LSB.
    rnd_sum = {1'b0, in_mant[24:1]} + {24'd0, in_mant[0] & in_mant[1]};
    if (rnd_sum[24]) begin
      rs_frac = rnd_sum[23:1];
      rs_exp  = {1'b0, in_exp} + 9'd2;
    end else begin
      rs_frac = rnd_sum[22:0];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    frac_d  = frac_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = DONE;
          if (in_mant == 25'd0) begin
            sign_d = 1'b0;
            exp_d  = 8'h00;
            frac_d = 23'd0;
            zero_d = 1'b1;
          end else if (in_mant[24]) begin
            if (rs_exp >= 9'd255) begin
              exp_d  = 8'hFF;
              frac_d = 23'd0;
              ovf_d  = 1'b1;
            end else begin
              exp_d  = rs_exp[7:0];
              frac_d = rs_frac;
            end
          end else if (in_exp == 8'h00) begin
            // A zero exponent cannot hold a normalized value.
            exp_d  = 8'h00;
            frac_d = 23'd0;
            unf_d  = 1'b1;
          end else if (in_exp == 8'hFF) begin
            exp_d  = 8'hFF;
            frac_d = 23'd0;
            ovf_d  = 1'b1;
          end else begin
            exp_d  = in_exp;
            frac_d = in_mant[22:0];
            if (!in_mant[23]) begin
              state_d = SHIFT;
            end
          end
        end
      end

      SHIFT: begin
        if (exp_q == 8'h01) begin
          // One more shift would drive the exponent to 0: flush instead.
          exp_d   = 8'h00;
          frac_d  = 23'd0;
          unf_d   = 1'b1;
          state_d = DONE;
        end else begin
          exp_d  = exp_q - 8'd1;
          frac_d = {frac_q[21:0], 1'b0};
          if (frac_q[22]) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= 8'h00;
      frac_q  <= 23'd0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      frac_q  <= frac_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = {sign_q, exp_q, frac_q};
  assign out_zero   = zero_q;
  assign out_ovf    = ovf_q;
  assign out_unf    = unf_q;

endmodule

// File: tb/tb_fp_normalizer.sv
module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_ovf;
  logic        out_unf;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] F_NONE = 32'd0;
  localparam logic [31:0] F_ZERO = 32'd4;
  localparam logic [31:0] F_OVF  = 32'd2;
  localparam logic [31:0] F_UNF  = 32'd1;

`ifdef FP_NORMALIZER_ROUND_EN
  localparam logic [31:0] R_TIE    = 32'h40000002;
  localparam logic [31:0] R_CARRY  = 32'h40800000;
  localparam logic [31:0] R_OVF    = 32'h7F800000;
  localparam logic [31:0] R_OVF_FL = 32'd2;
`else
  localparam logic [31:0] R_TIE    = 32'h40000001;
  localparam logic [31:0] R_CARRY  = 32'h407FFFFF;
  localparam logic [31:0] R_OVF    = 32'h7F7FFFFF;
  localparam logic [31:0] R_OVF_FL = 32'd0;
`endif

  always #5 clk = ~clk;

  fp_normalizer #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf),
    .out_unf    (out_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, out_zero, out_ovf, out_unf};
  endfunction

  task automatic accept_op(input logic s, input logic [7:0] e, input logic [24:0] m);
    @(negedge clk);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, " valid_after_pop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " ready_after_pop"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run(input string tag, input logic s, input logic [7:0] e,
                     input logic [24:0] m, input logic [31:0] res,
                     input logic [31:0] fl, input int exp_lat);
    int lat;
    accept_op(s, e, m);
    wait_done(lat);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " result"}, out_result, res);
    chk({tag, " flags"}, flags(), fl);
    consume(tag);
  endtask

  initial begin
    int lat;
    logic irdy_bad;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'h00;
    in_mant   = 25'd0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst out_result", out_result, 32'd0);
    chk("rst flags", flags(), F_NONE);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst in_ready", {31'd0, in_ready}, 32'd1);

    run("pass_one",   1'b0, 8'h7F, 25'h0800000, 32'h3F800000, F_NONE, 1);
    run("carry",      1'b0, 8'h80, 25'h1800000, 32'h40C00000, F_NONE, 1);
    run("neg_pass",   1'b1, 8'h80, 25'h0800000, 32'hC0000000, F_NONE, 1);
    run("zero",       1'b1, 8'h55, 25'h0000000, 32'h00000000, F_ZERO, 1);
    run("carry_ovf",  1'b0, 8'hFE, 25'h1000000, 32'h7F800000, F_OVF,  1);
    run("exp255",     1'b1, 8'hFF, 25'h0800000, 32'hFF800000, F_OVF,  1);
    run("exp0_unf",   1'b1, 8'h00, 25'h0400000, 32'h80000000, F_UNF,  1);
    run("shift_unf",  1'b0, 8'h02, 25'h0000001, 32'h00000000, F_UNF,  3);
    run("exp1_unf",   1'b0, 8'h01, 25'h0400000, 32'h00000000, F_UNF,  2);
    run("shift_exp1", 1'b0, 8'h02, 25'h0400000, 32'h00800000, F_NONE, 2);
    run("rnd_carry",  1'b0, 8'h7F, 25'h1FFFFFF, R_CARRY,      F_NONE, 1);
    run("rnd_ovf",    1'b0, 8'hFD, 25'h1FFFFFF, R_OVF,        R_OVF_FL, 1);

    // Five left shifts; in_ready must stay low until the result is popped.
    accept_op(1'b0, 8'h85, 25'h0040000);
    lat = 1;
    irdy_bad = 1'b0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0) irdy_bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    if (in_ready !== 1'b0) irdy_bad = 1'b1;
    chk("shift5 latency", lat, 6);
    chk("shift5 in_ready_low", {31'd0, irdy_bad}, 32'd0);
    chk("shift5 result", out_result, 32'h40000000);
    chk("shift5 flags", flags(), F_NONE);
    consume("shift5");

    // Tie-rounding case, with the consumer stalling for three cycles.
    accept_op(1'b0, 8'h7F, 25'h1000003);
    wait_done(lat);
    chk("tie latency", lat, 1);
    chk("tie result", out_result, R_TIE);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall result", out_result, R_TIE);
      chk("stall flags", flags(), F_NONE);
    end
    consume("tie");

    // Reset pulsed during the third SHIFT cycle.
    accept_op(1'b0, 8'h85, 25'h0040000);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_rel out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_rel in_ready", {31'd0, in_ready}, 32'd1);
    run("after_rst", 1'b0, 8'h7F, 25'h0800000, 32'h3F800000, F_NONE, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
